uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmit path (FIFO-fronted transmitter) among N_REQ byte sources.
//   Round-robin arbitration with a per-message lock: a granted source keeps the
//   transmitter until it sends a byte flagged 'last', or until it stalls for TIMEOUT cycles.
//   Sits between the requesters and the transmit controller's din/tx_en/tx_rdy interface.
// PARAMETERS
//   N_REQ    4    number of requesters (2..8)
//   TIMEOUT  255  consecutive idle cycles (req low while granted) before forced release; 0 = never
// PORTS
//   clk      in   1        system clock, all logic on posedge
//   rst      in   1        asynchronous, active-high reset
//   req      in   N_REQ    req[i]=1: source i has a byte on its data slice
//   last     in   N_REQ    last[i]=1: current byte of source i ends its message
//   data     in   8*N_REQ  byte of source i on data[8*i+7:8*i]
//   ack      out  N_REQ    one-cycle pulse: byte of source i taken this cycle
//   grant    out  N_REQ    one-hot owner of the transmitter, 0 when idle
//   tx_din   out  8        byte to transmit controller
//   tx_en    out  1        one-cycle strobe: tx_din valid
//   tx_rdy   in   1        transmit side can accept a byte (1 = ready)
//   busy     out  1        1 whenever grant != 0
// BEHAVIOUR
//   - All outputs registered. Reset: grant=0, ack=0, tx_en=0, tx_din=8'h00, busy=0,
//     state=IDLE, rr pointer=0, timeout counter=0. Reset mid-message drops the lock; no byte emitted.
//   - FSM IDLE -> XFER -> GAP -> XFER ... -> IDLE.
//   - IDLE: if req!=0, winner = first i with req[i]=1 scanning from rr pointer upward (wrapping
//     modulo N_REQ); grant<=onehot(winner), busy<=1, -> XFER. req==0: stay, grant=0.
//   - XFER (owner g): if req[g] && tx_rdy: tx_din<=data[g], tx_en<=1, ack[g]<=1 (same cycle),
//     counter<=0; if last[g] -> release, else -> GAP. If req[g] && !tx_rdy: wait, counter<=0.
//     If !req[g]: counter++; counter reaching TIMEOUT (TIMEOUT!=0) -> release.
//   - GAP: tx_en=0, ack=0 for exactly one cycle (downstream sees isolated one-cycle strobes,
//     max throughput 1 byte / 2 clk); -> XFER.
//   - Release: grant<=0, busy<=0, rr pointer<=(g+1) mod N_REQ, -> IDLE. Re-arbitration
//     needs one IDLE cycle; the releasing source may win again only if no other req is set.
//   - Latency: req in IDLE at cycle t -> grant at t+1 -> tx_en/ack at t+2 if tx_rdy high.
//   - ack and tx_en always coincide; ack is one-hot or zero; ack[i] only when grant[i].
//   - Requests of non-owners are ignored while locked (never acked, never dropped by arbiter).
//   - last[i] with req[i]=0 is ignored. tx_rdy is sampled only in XFER.
//   - Simultaneous last byte and new requests: release happens, new winner chosen next IDLE.
//   - Timeout counter width ceil(log2(TIMEOUT+1)); saturates, never wraps.
// CONFIGURATION
//   UART_ARB_FIXED_PRIO_EN defined: rr pointer removed; IDLE always picks lowest index
//     with req set (source 0 highest priority). Lock/timeout/GAP behaviour unchanged.
//   Not defined: round-robin as above.
// TESTING
//   1 Reset: assert rst mid-XFER of source 1 -> grant=0, tx_en=0, ack=0 same cycle; after
//     release, req=4'b0010 -> grant=4'b0010 one cycle later.
//   2 Single message: src0 sends 8'h41,8'h42,8'h43(last), tx_rdy=1 -> tx_en pulses 2 clk apart
//     with tx_din 41,42,43, ack[0] each time, grant back to 0 after 43.
//   3 Round-robin: req=4'b1111, each 1-byte last messages -> grant order 0,1,2,3,0; fixed-prio
//     build -> 0,0,0 while req[0] held.
//   4 Back-pressure: tx_rdy=0 for 20 cycles while src2 granted -> no tx_en, no ack, no
//     timeout; tx_rdy=1 -> byte sent next cycle.
//   5 Timeout: TIMEOUT=4, src1 sends non-last byte then drops req -> grant released after
//     4 idle cycles; pending src3 granted next; TIMEOUT=0 -> src1 held indefinitely.
//   6 Lock: src0 mid-message, src1 req high -> no ack[1] until src0 last byte, then grant=4'b0010.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-locked sharing of one UART transmit path among N_REQ sources.
// Round-robin by default; define UART_ARB_FIXED_PRIO_EN for fixed priority (source 0 first).
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   last,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_din,
    output logic               tx_en,
    input  logic               tx_rdy,
    output logic               busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    owner, owner_nxt, winner;
    logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
    logic [N_REQ-1:0] grant_nxt, ack_nxt;
    logic [7:0]       din_nxt, owner_byte;
    logic             en_nxt, busy_nxt, rel;

    // idle counter saturates so a long stall with TIMEOUT=0 never wraps
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        owner_byte = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner == IW'(k)) owner_byte = data[8*k +: 8];
        end
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) winner = IW'(k);
        end
    end
`else
    logic [IW-1:0]    rr, off, owner_inc;
    logic [N_REQ-1:0] rot;
    logic [IW:0]      sum;

    assign owner_inc = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // rotate requests so bit 0 is the source under the rr pointer
    always_comb begin
        rot = N_REQ'({req, req} >> rr);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum = {1'b0, rr} + {1'b0, off};
        if (sum >= (IW+1)'(N_REQ)) winner = IW'(sum - (IW+1)'(N_REQ));
        else winner = sum[IW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr <= '0;
        else if (rel) rr <= owner_inc;
    end
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        busy_nxt  = busy;
        din_nxt   = tx_din;
        ack_nxt   = '0;
        en_nxt    = 1'b0;
        rel       = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt = winner;
                    grant_nxt = N_REQ'(1) << winner;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (req[owner]) begin
                    cnt_nxt = '0;
                    if (tx_rdy) begin
                        din_nxt = owner_byte;
                        en_nxt  = 1'b1;
                        ack_nxt = grant;
                        if (last[owner]) rel = 1'b1;
                        else state_nxt = GAP;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    if (TIMEOUT != 0 && cnt_inc == CNT_LIM) rel = 1'b1;
                end
            end
            GAP: state_nxt = XFER;
            default: state_nxt = IDLE;
        endcase
        if (rel) begin
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            cnt    <= '0;
            grant  <= '0;
            ack    <= '0;
            tx_din <= 8'h00;
            tx_en  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            cnt    <= cnt_nxt;
            grant  <= grant_nxt;
            ack    <= ack_nxt;
            tx_din <= din_nxt;
            tx_en  <= en_nxt;
            busy   <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: queue-driven sources, message-level model of two arbiters
// (TIMEOUT=4 and TIMEOUT=0) checked every cycle, plus directed literal checks.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] last = '0;
    logic [8*N-1:0] data = '0;
    logic         tx_rdy = 1'b1;
    logic [N-1:0] ack_o [2];
    logic [N-1:0] grant_o [2];
    logic [7:0]   din_o [2];
    logic         en_o [2];
    logic         busy_o [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] sq [N][$];
    int txq[$];
    int txc[$];
    int glog[$];
    int prev_g = 0;

    int owner [2] = '{-1, -1};
    int idle_run [2] = '{0, 0};
    int ptr [2] = '{0, 0};
    bit gap [2] = '{0, 0};
    logic [N-1:0] e_ack [2] = '{'0, '0};
    logic [7:0]   e_din [2] = '{8'h00, 8'h00};
    bit           e_en [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(4)) u_t4 (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
        .ack(ack_o[0]), .grant(grant_o[0]), .tx_din(din_o[0]),
        .tx_en(en_o[0]), .tx_rdy(tx_rdy), .busy(busy_o[0])
    );

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(0)) u_t0 (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
        .ack(ack_o[1]), .grant(grant_o[1]), .tx_din(din_o[1]),
        .tx_en(en_o[1]), .tx_rdy(tx_rdy), .busy(busy_o[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic l);
        sq[i].push_back({l, b});
    endtask

    function automatic int to_of(input int m);
        return (m == 0) ? 4 : 0;
    endfunction

    function automatic int pick(input int p);
        int i;
        for (int k = 0; k < N; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            i = k;
`else
            i = (p + k) % N;
`endif
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant(input int m);
        if (owner[m] < 0) return '0;
        return N'(1) << owner[m];
    endfunction

    function automatic bit pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += sq[i].size();
        return (s != 0) || busy_o[0];
    endfunction

    task automatic drop(input int m);
        ptr[m] = (owner[m] + 1) % N;
        owner[m] = -1;
        idle_run[m] = 0;
        gap[m] = 1'b0;
    endtask

    // message-level view: owner, pending one-cycle gap, idle run length
    task automatic model_step(input int m);
        int w;
        e_ack[m] = '0;
        e_en[m] = 1'b0;
        if (owner[m] < 0) begin
            w = pick(ptr[m]);
            if (w >= 0) begin
                owner[m] = w;
                idle_run[m] = 0;
                gap[m] = 1'b0;
            end
        end else if (gap[m]) begin
            gap[m] = 1'b0;
        end else if (req[owner[m]]) begin
            idle_run[m] = 0;
            if (tx_rdy) begin
                e_din[m] = data[8*owner[m] +: 8];
                e_en[m] = 1'b1;
                e_ack[m] = N'(1) << owner[m];
                if (last[owner[m]]) drop(m);
                else gap[m] = 1'b1;
            end
        end else begin
            idle_run[m]++;
            if (to_of(m) != 0 && idle_run[m] >= to_of(m)) drop(m);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                owner[m] = -1;
                idle_run[m] = 0;
                ptr[m] = 0;
                gap[m] = 1'b0;
                e_ack[m] = '0;
                e_din[m] = 8'h00;
                e_en[m] = 1'b0;
            end else begin
                model_step(m);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("grant[u%0d]", m), int'(grant_o[m]), int'(exp_grant(m)));
            check($sformatf("ack[u%0d]", m), int'(ack_o[m]), int'(e_ack[m]));
            check($sformatf("tx_en[u%0d]", m), int'(en_o[m]), int'(e_en[m]));
            check($sformatf("tx_din[u%0d]", m), int'(din_o[m]), int'(e_din[m]));
            check($sformatf("busy[u%0d]", m), int'(busy_o[m]), int'(owner[m] >= 0));
        end
        if (en_o[0]) begin
            txq.push_back(int'(din_o[0]));
            txc.push_back(cyc);
        end
        if (grant_o[0] != '0 && prev_g == 0) glog.push_back(int'(grant_o[0]));
        prev_g = int'(grant_o[0]);
    end

    // sources: present queue head, pop it when the arbiter acks it
    initial forever begin
        logic [8:0] f;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (ack_o[0][i] && sq[i].size() != 0) void'(sq[i].pop_front());
            if (sq[i].size() != 0) begin
                f = sq[i][0];
                req[i] = 1'b1;
                last[i] = f[8];
                data[8*i +: 8] = f[7:0];
            end else begin
                req[i] = 1'b0;
                last[i] = 1'b0;
                data[8*i +: 8] = 8'h00;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        int exp3 [6];
`ifdef UART_ARB_FIXED_PRIO_EN
        exp3 = '{1, 1, 1, 2, 4, 8};
`else
        exp3 = '{1, 2, 4, 8, 1, 1};
`endif
        repeat (3) @(negedge clk);
        check("reset_grant", int'(grant_o[0]), 0);
        check("reset_busy", int'(busy_o[0]), 0);
        rst = 1'b0;

        // reset in the middle of a src1 message
        @(posedge clk); #1;
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b0);
        push(1, 8'h13, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!en_o[0] && k < 20);
        check("t1_first_byte", int'(din_o[0]), 'h11);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_grant", int'(grant_o[0]), 0);
        check("t1_rst_en", int'(en_o[0]), 0);
        check("t1_rst_ack", int'(ack_o[0]), 0);
        for (int i = 0; i < N; i++) sq[i].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        push(1, 8'h55, 1'b1);
        @(negedge clk);
        check("t1_idle_grant", int'(grant_o[0]), 0);
        @(negedge clk);
        check("t1_regrant", int'(grant_o[0]), 'b0010);
        k = 0;
        do begin @(negedge clk); k++; end while (pending() && k < 20);
        check("t1_done", int'(busy_o[0]), 0);

        // single three-byte message from src0
        @(posedge clk); #1;
        txq.delete(); txc.delete();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (pending() && k < 40);
        @(negedge clk);
        check("t2_count", txq.size(), 3);
        if (txq.size() == 3) begin
            check("t2_byte0", txq[0], 'h41);
            check("t2_byte1", txq[1], 'h42);
            check("t2_byte2", txq[2], 'h43);
            check("t2_gap01", txc[1] - txc[0], 2);
            check("t2_gap12", txc[2] - txc[1], 2);
        end
        check("t2_grant_idle", int'(grant_o[0]), 0);

        // arbitration order with every source requesting
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        glog.delete();
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA1, 1'b1);
        push(0, 8'hA2, 1'b1);
        push(1, 8'hB0, 1'b1);
        push(2, 8'hC0, 1'b1);
        push(3, 8'hD0, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (pending() && k < 80);
        @(negedge clk);
        check("t3_count", glog.size(), 6);
        for (int j = 0; j < 6; j++) begin
            n = (glog.size() > j) ? glog[j] : 0;
            check($sformatf("t3_order%0d", j), n, exp3[j]);
        end

        // back-pressure while src2 holds the lock
        tx_rdy = 1'b0;
        @(posedge clk); #1;
        push(2, 8'hE0, 1'b0);
        push(2, 8'hE1, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (grant_o[0] != 4'b0100 && k < 20);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (en_o[0] || ack_o[0] != '0) n++;
        end
        check("t4_no_strobe", n, 0);
        check("t4_held", int'(grant_o[0]), 'b0100);
        tx_rdy = 1'b1;
        @(negedge clk);
        check("t4_resume_en", int'(en_o[0]), 1);
        check("t4_resume_din", int'(din_o[0]), 'hE0);
        check("t4_resume_ack", int'(ack_o[0]), 'b0100);
        k = 0;
        do begin @(negedge clk); k++; end while (pending() && k < 20);

        // src1 request ignored until src0 finishes its message
        @(posedge clk); #1;
        txq.delete(); glog.delete();
        push(0, 8'h60, 1'b0);
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (grant_o[0] != 4'b0001 && k < 20);
        @(posedge clk); #1;
        push(1, 8'h70, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (pending() && k < 60);
        @(negedge clk);
        check("t6_count", txq.size(), 4);
        if (txq.size() == 4) begin
            check("t6_b0", txq[0], 'h60);
            check("t6_b1", txq[1], 'h61);
            check("t6_b2", txq[2], 'h62);
            check("t6_b3", txq[3], 'h70);
        end
        check("t6_grants", glog.size(), 2);
        if (glog.size() == 2) check("t6_second", glog[1], 'b0010);

        // src1 stalls mid-message: TIMEOUT=4 releases, TIMEOUT=0 holds
        @(posedge clk); #1;
        push(1, 8'h80, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (grant_o[0] != 4'b0010 && k < 20);
        @(posedge clk); #1;
        push(3, 8'h90, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!en_o[0] && k < 20);
        check("t5_byte", int'(din_o[0]), 'h80);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check($sformatf("t5_hold%0d", j), int'(grant_o[0]), 'b0010);
        end
        @(negedge clk);
        check("t5_release", int'(grant_o[0]), 0);
        check("t5_no_to_held", int'(grant_o[1]), 'b0010);
        @(negedge clk);
        check("t5_next_src3", int'(grant_o[0]), 'b1000);
        repeat (30) @(negedge clk);
        check("t5_no_to_still", int'(grant_o[1]), 'b0010);
        check("t5_no_to_busy", int'(busy_o[1]), 1);
        k = 0;
        do begin @(negedge clk); k++; end while (pending() && k < 20);
        check("t5_src3_done", int'(busy_o[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
